skew_delay_line: RTL
====================

# skew_delay_line

- Multi-lane, per-lane programmable operand delay line for the systolic array front end.
- Generalises the single-word stalled delay register to:
  - LANES independent channels;
  - a runtime-configurable delay of 0..MAX_DELAY extra cycles per lane;
  - valid tracking, flush, and guarded configuration.
- Sits between the weight/activation proxy and the array edge. It produces the diagonal skew, and lets BISR re-time a lane after remapping around a faulty PE.

## Interface
Parameters:
- WORD_SIZE, 16, signed data width per lane
- LANES, 4, number of channels
- MAX_DELAY, 8, largest programmable extra delay (≥1)
- DELAY_W, $clog2(MAX_DELAY+1), config delay field width

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  freezes all data and valid state while high
- flush  in  1  synchronous clear of in-flight data and valids
- d  in  LANES*WORD_SIZE  signed input words, lane i at [i*WORD_SIZE +: WORD_SIZE]
- d_valid  in  LANES  per-lane input valid
- q  out  LANES*WORD_SIZE  delayed signed output words
- q_valid  out  LANES  per-lane output valid
- cfg_we  in  1  configuration write strobe
- cfg_skew  in  1  mode written with cfg_we: 1 = programmed skew, 0 = uniform latency 1
- cfg_lane  in  $clog2(LANES) (min 1)  lane whose delay is written
- cfg_delay  in  DELAY_W  extra delay for cfg_lane
- cfg_err  out  1  one-cycle pulse: last cfg_we rejected
- busy  out  1  any valid bit set in any stage

## Operation
- Each lane holds a chain of MAX_DELAY+1 stages; each stage carries a word and a valid bit.
- Advance occurs when rst_n=1, flush=0 and stall=0. On an advance:
  - stage[0] <= d lane word and d_valid bit;
  - stage[k] <= stage[k-1].
- Output tap selection (combinational from stage registers):
  - skew mode: q and q_valid = stage[delay_i];
  - uniform mode: q and q_valid = stage[0].
- Reset state (asynchronous):
  - all stage words are 0 and all valids are 0, so q=0, q_valid=0, busy=0, cfg_err=0;
  - skew mode is on;
  - delay_i = min(i, MAX_DELAY), giving the classic diagonal skew.
- Stall: all stages hold and q/q_valid are stable. Config registers still accept writes if the legality rules below pass.
- Flush: all stage words go to 0 and all valids go to 0 on the next edge. Flush wins over stall and over a same-cycle input. Config registers are kept.
- Config write, with cfg_we=1 sampled on an edge:
  - Accepted only if busy=0 in that cycle, cfg_lane < LANES, and cfg_delay ≤ MAX_DELAY.
  - If accepted: the mode register <= cfg_skew, and delay[cfg_lane] <= cfg_delay.
  - Otherwise nothing changes and cfg_err=1 for exactly the next cycle.
- A cfg_we coincident with flush is judged against the pre-flush busy value.
- Words are passed unmodified; no arithmetic, sign preserved.
- Stages beyond the selected tap continue to shift. Their contents are invisible except through busy.

## Timing
- Latency from d to q:
  - skew mode: delay_i+1 advance cycles;
  - uniform mode: 1 advance cycle;
  - each stalled cycle adds exactly 1 cycle.
- Throughput: one word per lane per non-stalled cycle, no bubbles inserted.
- Config takes effect from the cycle after the accepting edge.
- Input to the first tapped word after a config change must wait until busy=0.
- busy covers all MAX_DELAY+1 stages, including those past the tap. After the last valid input, busy falls MAX_DELAY+1 advance cycles later, or one edge after flush.
- rst_n assertion mid-stream clears all state immediately, without waiting for a clock. The first advance occurs on the first rising edge with rst_n=1.

## Test plan
- Reset skew, diagonal alignment:
  - Stimulus: after reset, drive d_valid=4'hF with all lanes = 16'h0011*k on cycle k=1..6.
  - Response: lane i first shows 16'h0011 with q_valid=1 i+1 edges after the first input.
  - Response: lane 3 shows 16'h0066 on edge 9.
  - Response: busy stays high until edge 15, then drops.
- Stall: same stream with stall=1 for edges 3–4.
  - q/q_valid are unchanged across those edges.
  - Every lane's output sequence shifts 2 cycles later; no word is lost or duplicated.
- Config guard:
  - While busy=1, write cfg_lane=2, cfg_delay=5: cfg_err pulses once and lane 2 latency stays 3.
  - While idle, write cfg_lane=2, cfg_delay=5: no error and lane 2 latency becomes 6.
  - Write cfg_delay=9 with MAX_DELAY=8: rejected with cfg_err.
- Uniform mode:
  - Write cfg_skew=0 while idle, then drive 16'h8001 (negative) on all lanes.
  - All lanes output 16'h8001 one edge later with q_valid=4'hF.
- Flush priority:
  - Assert flush together with stall and d_valid=4'hF mid-stream.
  - Next edge: q_valid=0 and busy=0; q=0 on all lanes; the config readback latency is unchanged.
- Async reset mid-stream:
  - Drop rst_n between edges while busy=1.
  - Outputs go to 0 and busy goes to 0 before the next edge; delays return to 0,1,2,3.

Source files
------------

// File: rtl/skew_delay_line.sv
// skew_delay_line
// Multi-lane programmable delay line feeding the systolic array edge. Each
// lane is a MAX_DELAY+1 deep shift chain of (word, valid) stages. The output
// tap is stage[delay_i] in skew mode or stage[0] in uniform mode, so the
// latency from d to q is delay_i+1 or 1 advance cycles respectively.
//
// Valid semantics: a word is transferred on every edge where the line
// advances (rst_n=1, flush=0, stall=0), whatever d_valid is; d_valid only
// marks whether the word is meaningful. There is no backpressure toward the
// source: stall freezes the line and the source must hold off as well.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   stall      hold all stage data and valids
//   flush      clear all stage data and valids on the next edge (beats stall)
//   d          LANES packed signed words, lane i at [i*WORD_SIZE +: WORD_SIZE]
//   d_valid    per-lane input valid
//   q          per-lane delayed words (same packing as d)
//   q_valid    per-lane output valid
//   cfg_we     configuration write strobe
//   cfg_skew   mode written with cfg_we (1 = programmed skew, 0 = uniform)
//   cfg_lane   lane whose delay is written
//   cfg_delay  extra delay for cfg_lane
//   cfg_err    one-cycle pulse after a rejected cfg_we
//   busy       any valid bit held in any stage of any lane
module skew_delay_line #(
   parameter int WORD_SIZE = 16,
   parameter int LANES     = 4,
   parameter int MAX_DELAY = 8,
   parameter int DELAY_W   = $clog2(MAX_DELAY + 1),
   parameter int LANE_W    = (LANES > 1) ? $clog2(LANES) : 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         stall,
   input  logic                         flush,
   input  logic [LANES*WORD_SIZE-1:0]   d,
   input  logic [LANES-1:0]             d_valid,
   output logic [LANES*WORD_SIZE-1:0]   q,
   output logic [LANES-1:0]             q_valid,
   input  logic                         cfg_we,
   input  logic                         cfg_skew,
   input  logic [LANE_W-1:0]            cfg_lane,
   input  logic [DELAY_W-1:0]           cfg_delay,
   output logic                         cfg_err,
   output logic                         busy
);

   logic [WORD_SIZE-1:0] stage_word  [LANES][MAX_DELAY+1];
   logic [MAX_DELAY:0]   stage_valid [LANES];
   logic [DELAY_W-1:0]   delay_r     [LANES];
   logic                 skew_mode;
   logic                 cfg_err_r;
   logic                 busy_w;
   logic                 cfg_ok;

   // busy looks at every stage, including those past the tap, so a config
   // change can never retime a word that is still inside the chain.
   always_comb begin
      busy_w = 1'b0;
      for (int i = 0; i < LANES; i++) begin
         busy_w = busy_w | (|stage_valid[i]);
      end
   end

   // Judged on the current (pre-flush) busy value.
   assign cfg_ok = cfg_we && !busy_w
                   && (int'(cfg_lane) < LANES)
                   && (int'(cfg_delay) <= MAX_DELAY);

   // Stage chains
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LANES; i++) begin
            stage_valid[i] <= '0;
            for (int k = 0; k <= MAX_DELAY; k++) begin
               stage_word[i][k] <= '0;
            end
         end
      end else if (flush) begin
         for (int i = 0; i < LANES; i++) begin
            stage_valid[i] <= '0;
            for (int k = 0; k <= MAX_DELAY; k++) begin
               stage_word[i][k] <= '0;
            end
         end
      end else if (!stall) begin
         for (int i = 0; i < LANES; i++) begin
            stage_valid[i]   <= {stage_valid[i][MAX_DELAY-1:0], d_valid[i]};
            stage_word[i][0] <= d[i*WORD_SIZE +: WORD_SIZE];
            for (int k = 1; k <= MAX_DELAY; k++) begin
               stage_word[i][k] <= stage_word[i][k-1];
            end
         end
      end
   end

   // Configuration; writes are accepted regardless of stall or flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skew_mode <= 1'b1;
         cfg_err_r <= 1'b0;
         for (int i = 0; i < LANES; i++) begin
            delay_r[i] <= DELAY_W'((i < MAX_DELAY) ? i : MAX_DELAY);
         end
      end else begin
         cfg_err_r <= cfg_we && !cfg_ok;
         if (cfg_ok) begin
            skew_mode         <= cfg_skew;
            delay_r[cfg_lane] <= cfg_delay;
         end
      end
   end

   // Output tap; the compare loop keeps the select inside the chain even if
   // DELAY_W could encode values beyond MAX_DELAY.
   always_comb begin
      q       = '0;
      q_valid = '0;
      for (int i = 0; i < LANES; i++) begin
         if (!skew_mode) begin
            q[i*WORD_SIZE +: WORD_SIZE] = stage_word[i][0];
            q_valid[i]                  = stage_valid[i][0];
         end else begin
            for (int k = 0; k <= MAX_DELAY; k++) begin
               if (int'(delay_r[i]) == k) begin
                  q[i*WORD_SIZE +: WORD_SIZE] = stage_word[i][k];
                  q_valid[i]                  = stage_valid[i][k];
               end
            end
         end
      end
   end

   assign cfg_err = cfg_err_r;
   assign busy    = busy_w;

endmodule
